// File: rtl/norm_mult_sched.sv
// norm_mult_sched
//   Shares one external 32x32 fixed-point multiplier (62-bit product) between
//   NREQ requesters, e.g. input normalisation (operand x 1/max scale) and the
//   ln-series multiply steps of the natural-log unit. Round-robin arbitration
//   is used and only one operation is in flight at a time. The product is
//   sliced to a 32-bit result, RES_Y = MUL_Y[SLICE_LSB+31:SLICE_LSB].
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. On the request side req_ready is a one-hot grant offered
//   only in IDLE. On the result side res_valid/res_id/res_y hold steady until
//   res_ready is seen.
//
// Ports
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   req_valid     [NREQ]    request i presents operands
//   req_a, req_b  [32*NREQ] operands of request i at bits [32i+31:32i]
//   req_ready     [NREQ]    one-hot grant
//   mul_a, mul_b  [32]      registered operands to the shared multiplier
//   mul_y         [62]      product from the shared multiplier
//   res_valid     result available
//   res_id        [2]       requester that owns res_y
//   res_y         [32]      sliced result
//   res_ready     consumer accepts the result
//   dbg_state     [2]       FSM state (0 IDLE, 1 BUSY, 2 DONE)
module norm_mult_sched #(
  parameter int NREQ      = 2,
  parameter int MUL_LAT   = 1,
  parameter int SLICE_LSB = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [61:0]          mul_y,
  output logic                 res_valid,
  output logic [1:0]           res_id,
  output logic [31:0]          res_y,
  input  logic                 res_ready,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [31:0]      res_y_q, res_y_d;
  logic [1:0]       res_id_q, res_id_d;
  logic             res_valid_q, res_valid_d;

  logic [3:0]       valid_ext;
  logic [2:0]       idx_w;
  logic             gnt_found;
  logic [1:0]       gnt_idx;
  logic [31:0]      sel_a, sel_b;

  // Bits of the product outside the slice are intentionally discarded.
  logic             unused_mul_bits;
  assign unused_mul_bits = ^mul_y;

  // Round-robin search: first valid requester at or above rr_q, wrapping.
  // Requests are zero-extended to 4 so indices >= NREQ are never valid.
  always_comb begin
    valid_ext = 4'(req_valid);
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    idx_w     = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = 3'(rr_q) + 3'(k);
      if (idx_w >= 3'(NREQ)) idx_w = idx_w - 3'(NREQ);
      if (!gnt_found && valid_ext[idx_w[1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_w[1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == 2'(k)) begin
        sel_a = req_a[32*k +: 32];
        sel_b = req_b[32*k +: 32];
      end
    end
  end

  // Grant is combinational from state and requests; it is also forced low
  // while reset is asserted so that every output shows its reset value.
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = rst_n && (state_q == S_IDLE) && gnt_found && (gnt_idx == 2'(k));
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_y_d     = res_y_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          mul_a_d  = sel_a;
          mul_b_d  = sel_b;
          res_id_d = gnt_idx;
          rr_d     = (gnt_idx == 2'(NREQ-1)) ? 2'd0 : gnt_idx + 2'd1;
          cnt_d    = CNT_W'(MUL_LAT-1);
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        // Product is sampled exactly MUL_LAT edges after the accept edge.
        if (cnt_q == '0) begin
          res_y_d     = mul_y[SLICE_LSB +: 32];
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // No grant in the cycle of the result transfer.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 2'd0;
      cnt_q       <= '0;
      mul_a_q     <= 32'd0;
      mul_b_q     <= 32'd0;
      res_y_q     <= 32'd0;
      res_id_q    <= 2'd0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_y_q     <= res_y_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_y     = res_y_q;
  assign res_id    = res_id_q;
  assign res_valid = res_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_norm_mult_sched.sv
// tb_norm_mult_sched
//   Two instances: u_dut1 with a combinational multiplier (MUL_LAT=1) and
//   u_dut3 with a 3-cycle multiplier model (MUL_LAT=3). Expected results are
//   hand-computed constants pushed into a per-instance queue when a request
//   is issued; a monitor per instance pops and compares on each result
//   transfer. Inputs change #1 after the rising edge, outputs are sampled on
//   the falling edge.
module tb_norm_mult_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        rst_n1, rst_n3;
  logic [1:0]  req_valid1, req_valid3, req_ready1, req_ready3;
  logic [63:0] req_a1, req_b1, req_a3, req_b3;
  logic [31:0] mul_a1, mul_b1, mul_a3, mul_b3;
  logic [61:0] mul_y1, mul_y3;
  logic        res_valid1, res_valid3, res_ready1, res_ready3;
  logic [1:0]  res_id1, res_id3, dbg_state1, dbg_state3;
  logic [31:0] res_y1, res_y3;

  logic [33:0] exp_q1[$];
  logic [33:0] exp_q3[$];
  logic [33:0] e1, e3;

  logic [1:0]  gr[4];
  int          tg[4];
  int          ngr, cyc, n;

  norm_mult_sched #(.NREQ(2), .MUL_LAT(1), .SLICE_LSB(22)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .req_valid(req_valid1), .req_a(req_a1), .req_b(req_b1),
    .req_ready(req_ready1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_y(mul_y1),
    .res_valid(res_valid1), .res_id(res_id1), .res_y(res_y1), .res_ready(res_ready1),
    .dbg_state(dbg_state1));

  norm_mult_sched #(.NREQ(2), .MUL_LAT(3), .SLICE_LSB(22)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_ready(req_ready3), .mul_a(mul_a3), .mul_b(mul_b3), .mul_y(mul_y3),
    .res_valid(res_valid3), .res_id(res_id3), .res_y(res_y3), .res_ready(res_ready3),
    .dbg_state(dbg_state3));

  function automatic logic [61:0] mul62(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[61:0];
  endfunction

  assign mul_y1 = mul62(mul_a1, mul_b1);

  // 3-cycle multiplier: two register stages after the registered operands.
  logic [61:0] pipe1_3 = '0;
  logic [61:0] pipe2_3 = '0;
  always @(posedge clk) begin
    pipe1_3 <= mul62(mul_a3, mul_b3);
    pipe2_3 <= pipe1_3;
  end
  assign mul_y3 = pipe2_3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (rst_n1 && res_valid1 && res_ready1) begin
      if (exp_q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut1 result with empty queue: got id %0d y %0h", res_id1, res_y1);
      end else begin
        e1 = exp_q1.pop_front();
        chk("dut1 res_id", 64'(res_id1), 64'(e1[33:32]));
        chk("dut1 res_y", 64'(res_y1), 64'(e1[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n3 && res_valid3 && res_ready3) begin
      if (exp_q3.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut3 result with empty queue: got id %0d y %0h", res_id3, res_y3);
      end else begin
        e3 = exp_q3.pop_front();
        chk("dut3 res_id", 64'(res_id3), 64'(e3[33:32]));
        chk("dut3 res_y", 64'(res_y3), 64'(e3[31:0]));
      end
    end
  end

  // One request on u_dut1 with res_ready high; checks grant and latency.
  task automatic issue1(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y, input string tag);
    int k;
    req_a1[32*idx +: 32] = a;
    req_b1[32*idx +: 32] = b;
    req_valid1 = 2'(1 << idx);
    @(negedge clk);
    chk({tag, " grant"}, 64'(req_ready1), 64'(1 << idx));
    exp_q1.push_back({2'(idx), y});
    @(posedge clk); #1;
    req_valid1 = 2'b00;
    k = 0;
    while (!res_valid1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'd1);
    @(posedge clk); #1;
  endtask

  // One request on u_dut3; checks operand stability and 3-edge latency.
  task automatic issue3(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y, input string tag);
    int k;
    req_a3[32*idx +: 32] = a;
    req_b3[32*idx +: 32] = b;
    req_valid3 = 2'(1 << idx);
    @(negedge clk);
    chk({tag, " grant"}, 64'(req_ready3), 64'(1 << idx));
    exp_q3.push_back({2'(idx), y});
    @(posedge clk); #1;
    req_valid3 = 2'b00;
    k = 0;
    while (!res_valid3 && k < 10) begin
      @(negedge clk);
      chk({tag, " mul_a stable"}, 64'(mul_a3), 64'(a));
      chk({tag, " mul_b stable"}, 64'(mul_b3), 64'(b));
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'd3);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n1 = 1'b0; rst_n3 = 1'b0;
    req_valid1 = 2'b11; req_valid3 = 2'b00;
    req_a1 = '0; req_b1 = '0; req_a3 = '0; req_b3 = '0;
    res_ready1 = 1'b1; res_ready3 = 1'b1;

    // Reset values (requests asserted to show the grant is suppressed).
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 64'(req_ready1), 64'd0);
    chk("rst res_valid", 64'(res_valid1), 64'd0);
    chk("rst res_id", 64'(res_id1), 64'd0);
    chk("rst res_y", 64'(res_y1), 64'd0);
    chk("rst mul_a", 64'(mul_a1), 64'd0);
    chk("rst mul_b", 64'(mul_b1), 64'd0);
    chk("rst state", 64'(dbg_state1), 64'd0);
    @(posedge clk); #1;
    req_valid1 = 2'b00;
    rst_n1 = 1'b1;
    @(posedge clk); #1;

    // Single requests, alternating index so the pointer ends at 0.
    issue1(0, 32'h40000000, 32'h00CC710C, 32'hCC710C00, "t1 norm");
    issue1(1, 32'h00000400, 32'h00001000, 32'h00000001, "lsb");
    issue1(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFF800, "t6 max");
    issue1(1, 32'h80000000, 32'h80000000, 32'h00000000, "trunc");

    // Both requesters valid continuously: 0,1,0,1 every 3 cycles.
    req_a1 = {32'h12345678, 32'h00010000};
    req_b1 = {32'h00400000, 32'h00010000};
    exp_q1.push_back({2'd0, 32'h00000400});
    exp_q1.push_back({2'd1, 32'h12345678});
    exp_q1.push_back({2'd0, 32'h00000400});
    exp_q1.push_back({2'd1, 32'h12345678});
    req_valid1 = 2'b11;
    ngr = 0; cyc = 0;
    while (ngr < 4 && cyc < 40) begin
      @(negedge clk);
      if (req_ready1 != 2'b00) begin
        gr[ngr] = req_ready1;
        tg[ngr] = cyc;
        ngr++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid1 = 2'b00;
    chk("t2 grant count", 64'(ngr), 64'd4);
    chk("t2 grant 0", 64'(gr[0]), 64'd1);
    chk("t2 grant 1", 64'(gr[1]), 64'd2);
    chk("t2 grant 2", 64'(gr[2]), 64'd1);
    chk("t2 grant 3", 64'(gr[3]), 64'd2);
    for (int i = 1; i < 4; i++) chk("t2 interval", 64'(tg[i] - tg[i-1]), 64'd3);
    n = 0;
    while (exp_q1.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t2 drain", 64'(exp_q1.size()), 64'd0);
    @(posedge clk); #1;

    // Result back-pressure for 5 cycles while requester 1 waits.
    res_ready1 = 1'b0;
    req_a1 = {32'h00010000, 32'h12345678};
    req_b1 = {32'h00010000, 32'h00400000};
    req_valid1 = 2'b01;
    @(negedge clk);
    chk("t3 grant0", 64'(req_ready1), 64'd1);
    exp_q1.push_back({2'd0, 32'h12345678});
    @(posedge clk); #1;
    req_valid1 = 2'b10;
    n = 0;
    while (!res_valid1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t3 latency", 64'(n), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3 hold res_valid", 64'(res_valid1), 64'd1);
      chk("t3 hold res_y", 64'(res_y1), 64'h12345678);
      chk("t3 hold res_id", 64'(res_id1), 64'd0);
      chk("t3 hold req_ready", 64'(req_ready1), 64'd0);
      @(posedge clk); #1;
    end
    res_ready1 = 1'b1;
    @(negedge clk);
    chk("t3 no grant in transfer cycle", 64'(req_ready1), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3 next grant", 64'(req_ready1), 64'd2);
    exp_q1.push_back({2'd1, 32'h00000400});
    @(posedge clk); #1;
    req_valid1 = 2'b00;
    n = 0;
    while (exp_q1.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t3 drain", 64'(exp_q1.size()), 64'd0);

    // MUL_LAT=3 instance.
    rst_n3 = 1'b1;
    @(posedge clk); #1;
    issue3(0, 32'h12345678, 32'h00000400, 32'h00012345, "t4 a");
    issue3(0, 32'h00010000, 32'h00010000, 32'h00000400, "t4 b");

    // Asynchronous reset while BUSY; pointer is 1 before the pulse.
    req_a3 = {32'h00000400, 32'h40000000};
    req_b3 = {32'h00001000, 32'h00CC710C};
    req_valid3 = 2'b01;
    @(negedge clk);
    chk("t5 grant before reset", 64'(req_ready3), 64'd1);
    @(posedge clk); #1;
    req_valid3 = 2'b11;
    #2;
    rst_n3 = 1'b0;
    #1;
    chk("t5 async res_valid", 64'(res_valid3), 64'd0);
    chk("t5 async req_ready", 64'(req_ready3), 64'd0);
    chk("t5 async mul_a", 64'(mul_a3), 64'd0);
    chk("t5 async mul_b", 64'(mul_b3), 64'd0);
    chk("t5 async state", 64'(dbg_state3), 64'd0);
    @(posedge clk); #1;
    rst_n3 = 1'b1;
    @(negedge clk);
    chk("t5 first grant after reset", 64'(req_ready3), 64'd1);
    exp_q3.push_back({2'd0, 32'hCC710C00});
    @(posedge clk); #1;
    req_valid3 = 2'b00;
    n = 0;
    while (exp_q3.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5 drain", 64'(exp_q3.size()), 64'd0);
    chk("dut1 queue empty", 64'(exp_q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
